decoder_3x8_pulse: RTL and testbench
====================================

# decoder_3x8_pulse

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It takes a 3-bit code and drives exactly one of eight select lines for a requested number of cycles. A forced all-zero gap cycle follows each pulse, giving break-before-make. It is the receive side of the 8-to-3 encoder path: the encoder produces codes, and this block turns them back into timed one-hot selects for downstream channel logic.

## Interface
- HOLD_W, 4, width of the hold-length field; maximum hold is 2^HOLD_W - 1 cycles.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  code/hold pair is offered.
- in_ready  out  1  block can accept; registered.
- in_code  in  3  binary select index, 0..7.
- in_hold  in  HOLD_W  pulse length in cycles; 0 is treated as 1.
- out_onehot  out  8  registered one-hot select; all-zero when idle.
- out_valid  out  1  high while out_onehot is non-zero.
- busy  out  1  high in ACTIVE or GAP.
- in_par  in  1  even-parity bit over in_code; present only with DECODER_3X8_PARITY_EN.
- err  out  1  sticky parity error; present only with DECODER_3X8_PARITY_EN.

## Operation
- Three-state FSM:
  - IDLE: in_ready=1. Handshake = in_valid & in_ready. On handshake, register onehot = 8'b1 << in_code and cnt = max(in_hold,1) - 1, then go to ACTIVE.
  - ACTIVE: out_onehot holds the value and out_valid=1. If cnt==0, go to GAP and clear out_onehot. Otherwise decrement cnt.
  - GAP: out_onehot=0, out_valid=0, in_ready=0 for exactly 1 cycle, then go to IDLE.
- in_ready is high only in IDLE. It is registered, so it falls on the edge that accepts and rises on the edge leaving GAP.
- Inputs are sampled only at the handshake edge. Changes to in_code or in_hold during ACTIVE are ignored.
- out_onehot is never multi-hot and never X, including for any in_code value.
- in_hold=0 behaves exactly like in_hold=1.
- Async reset at any time, including mid-pulse:
  - state goes to IDLE, cnt=0, out_onehot=0, out_valid=0, busy=0, in_ready=0, err=0.
  - in_ready rises on the first rising edge after rst is deasserted.
  - A pulse in progress is discarded, not resumed.

## Timing
- Handshake at edge N:
  - out_onehot and out_valid are valid after edge N.
  - They stay valid for H = max(in_hold,1) cycles and clear at edge N+H.
  - GAP occupies N+H..N+H+1. in_ready is high again after edge N+H+1.
- Throughput: one code per H+2 cycles when in_valid is held high continuously.
- busy asserts after edge N and deasserts after edge N+H+1.
- No combinational path from any input to any output.

## Configuration
- DECODER_3X8_PARITY_EN defined:
  - in_par and err ports exist.
  - A handshake where ^{in_code,in_par} = 1 is consumed: in_ready pulses low for 1 cycle and no pulse is issued.
  - err sets on the next edge and stays set until reset.
  - State returns to IDLE without passing through ACTIVE or GAP.
- DECODER_3X8_PARITY_EN undefined:
  - in_par and err ports are absent.
  - Every handshake is decoded.

## Structure
- Package decoder_3x8_pkg holds:
  - state enum {IDLE, ACTIVE, GAP}, 2 bits.
  - localparam NUM_OUT=8 and CODE_W=3.
  - function onehot_of(code) returning the 8-bit shifted one-hot.
- One natural sub-module: decoder_hold_cnt.
  - Loadable down-counter of width HOLD_W with load, load value, and a zero flag.
  - Async reset to 0.
- The FSM and output registers live in the top module.

## Test plan
- Reset then idle: rst high 3 cycles, then low. Expect out_onehot=8'h00, in_ready=0 during reset, and in_ready=1 after the first edge.
- Single decode: code=3'd5, hold=3, one-cycle valid. Expect out_onehot=8'h20 for exactly 3 cycles, then 8'h00, and in_ready back after 5 cycles total.
- Sweep with back-to-back valid: codes 0..7 with hold=1. Expect 8'h01, 02, 04 … 80, each for 1 cycle, separated by 2 zero cycles (GAP and IDLE), with no overlap.
- Hold=0 and hold=15 (HOLD_W=4): code 2 gives 8'h04 for 1 cycle and for 15 cycles respectively. Changing in_code mid-pulse has no effect.
- Reset mid-pulse: code 7, hold 10, rst asserted asynchronously at cycle 4. Expect out_onehot=0 immediately, with no further pulse after release.
- With DECODER_3X8_PARITY_EN: code=3'd1, in_par=0. Expect no pulse, err=1 and sticky. Next, code=3'd1, in_par=1: expect 8'h02 for its hold while err stays 1.

Source files
------------

// File: rtl/decoder_3x8_pkg.sv
// Shared types and helpers for the registered 3-to-8 pulse decoder.
package decoder_3x8_pkg;

    localparam int NUM_OUT = 8;
    localparam int CODE_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    function automatic logic [NUM_OUT-1:0] onehot_of(input logic [CODE_W-1:0] code);
        onehot_of = {{(NUM_OUT-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage

// File: rtl/decoder_hold_cnt.sv
// Loadable down-counter that times the active phase of a decoded pulse.
module decoder_hold_cnt #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_3x8_pulse.sv
// Registered 3-to-8 one-hot decoder with valid/ready intake, programmable hold and a forced gap cycle.
// Optional parity check on the incoming code is enabled by defining DECODER_3X8_PARITY_EN.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a handshake
// ACTIVE | one select line driven, hold counter running
// GAP    | all selects low for one cycle (break-before-make)
module decoder_3x8_pulse
    import decoder_3x8_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  in_code,
    input  logic [HOLD_W-1:0]  in_hold,
`ifdef DECODER_3X8_PARITY_EN
    input  logic               in_par,
    output logic               err,
`endif
    output logic [NUM_OUT-1:0] out_onehot,
    output logic               out_valid,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] onehot_q, onehot_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               hs;
    logic               par_bad;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [HOLD_W-1:0]  hold_eff;
    logic [HOLD_W-1:0]  cnt_load_val;

    assign hs = in_valid & in_ready_q;

`ifdef DECODER_3X8_PARITY_EN
    logic err_q, err_d;
    assign par_bad = ^{in_code, in_par};
    assign err     = err_q;
`else
    assign par_bad = 1'b0;
`endif

    // A zero hold request is stretched to one cycle; the counter holds H-1.
    assign hold_eff     = (in_hold == '0) ? {{(HOLD_W-1){1'b0}}, 1'b1} : in_hold;
    assign cnt_load_val = hold_eff - {{(HOLD_W-1){1'b0}}, 1'b1};

    decoder_hold_cnt #(
        .HOLD_W(HOLD_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            onehot_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DECODER_3X8_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            onehot_q   <= onehot_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
`ifdef DECODER_3X8_PARITY_EN
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs && !par_bad) state_d = ACTIVE;
            ACTIVE:  if (cnt_zero) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        onehot_d   = onehot_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        // A rejected handshake keeps us in IDLE but still drops ready for one cycle.
        in_ready_d = (state_d == IDLE) && !hs;
        busy_d     = (state_d != IDLE);
`ifdef DECODER_3X8_PARITY_EN
        err_d      = err_q | (hs & par_bad);
`endif
        case (state_q)
            IDLE: begin
                if (hs && !par_bad) begin
                    onehot_d = onehot_of(in_code);
                    cnt_load = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_zero) begin
                    onehot_d = '0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: onehot_d = '0;
        endcase
    end

    assign out_onehot = onehot_q;
    assign out_valid  = |onehot_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// Self-checking bench for decoder_3x8_pulse: timeline reference model plus directed and random stimulus.
module tb_decoder_3x8_pulse;

    localparam int BIG = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic [3:0] in_hold = '0;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       busy;
`ifdef DECODER_3X8_PARITY_EN
    logic       in_par = 1'b0;
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    decoder_3x8_pulse #(.HOLD_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_hold    (in_hold),
`ifdef DECODER_3X8_PARITY_EN
        .in_par     (in_par),
        .err        (err),
`endif
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted pulse is a time window [start, start+H) of its one-hot,
    // busy through start+H, ready again from start+H+1.
    int         cyc = 0;
    int         ready_from = BIG;
    bit         arm = 1'b1;
    bit         p_valid = 1'b0;
    int         p_start = 0;
    int         p_end = 0;
    logic [7:0] p_oh = '0;
    bit         err_m = 1'b0;
    int         hs_cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid    = 1'b0;
            ready_from = BIG;
            arm        = 1'b1;
            err_m      = 1'b0;
        end else begin
            bit rdy_prev;
            bit bad;
            int h;
            rdy_prev = (cyc >= ready_from);
            cyc++;
            bad = 1'b0;
`ifdef DECODER_3X8_PARITY_EN
            bad = ^{in_code, in_par};
`endif
            if (arm) begin
                ready_from = cyc;
                arm        = 1'b0;
            end else if (in_valid && rdy_prev) begin
                if (bad) begin
                    err_m      = 1'b1;
                    ready_from = cyc + 1;
                end else begin
                    h          = (in_hold == 0) ? 1 : int'(in_hold);
                    p_valid    = 1'b1;
                    p_start    = cyc;
                    p_end      = cyc + h;
                    p_oh       = 8'(1 << in_code);
                    ready_from = cyc + h + 1;
                    hs_cyc     = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e_oh;
        e_oh = (p_valid && cyc >= p_start && cyc < p_end) ? p_oh : 8'h00;
        chk("model_onehot", 32'(out_onehot), 32'(e_oh));
        chk("model_out_valid", 32'(out_valid), 32'(e_oh != 8'h00));
        chk("model_in_ready", 32'(in_ready), 32'(cyc >= ready_from));
        chk("model_busy", 32'(busy), 32'(p_valid && cyc >= p_start && cyc <= p_end));
`ifdef DECODER_3X8_PARITY_EN
        chk("model_err", 32'(err), 32'(err_m));
`endif
    end

    task automatic set_code(input logic [2:0] c);
        in_code = c;
`ifdef DECODER_3X8_PARITY_EN
        in_par = ^c;
`endif
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL wait_ready: in_ready still %b after %0d cycles, required 1", in_ready, n);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic pulse(input logic [2:0] code, input logic [3:0] hold,
                         input logic [7:0] exp_oh, input int exp_len, input bit scramble);
        bit ok;
        int len;
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1;
        set_code(code);
        in_hold  = hold;
        @(negedge clk);
        in_valid = scramble;
        len = 0;
        while (out_onehot === exp_oh && len < 40) begin
            if (scramble) begin
                set_code(3'($urandom));
                in_hold = 4'($urandom);
            end
            @(negedge clk);
            len++;
        end
        in_valid = 1'b0;
        chk("pulse_len", 32'(len), 32'(exp_len));
        chk("gap_onehot", 32'(out_onehot), 32'h0);
        chk("gap_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("ready_back", 32'(in_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sweep_tbl [8];
        int         sweep_hs [8];
        bit         ok;
        int         nz;
        sweep_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_onehot", 32'(out_onehot), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);
`ifdef DECODER_3X8_PARITY_EN
        chk("rst_err", 32'(err), 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_first_edge", 32'(in_ready), 32'h1);

        pulse(3'd5, 4'd3, 8'h20, 3, 1'b0);
        pulse(3'd2, 4'd0, 8'h04, 1, 1'b0);
        pulse(3'd2, 4'd15, 8'h04, 15, 1'b1);
        pulse(3'd6, 4'd2, 8'h40, 2, 1'b1);

        in_hold  = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_code(3'(i));
            wait_ready(ok);
            @(negedge clk);
            sweep_hs[i] = hs_cyc;
            chk("sweep_onehot", 32'(out_onehot), 32'(sweep_tbl[i]));
        end
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            chk("sweep_spacing", 32'(sweep_hs[i] - sweep_hs[i-1]), 32'd3);
        end

        wait_ready(ok);
        in_valid = 1'b1;
        set_code(3'd7);
        in_hold  = 4'd10;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_pulse_on", 32'(out_onehot), 32'h80);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_onehot", 32'(out_onehot), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nz = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_onehot != 8'h00) nz++;
        end
        chk("midrst_no_resume", 32'(nz), 32'h0);

`ifdef DECODER_3X8_PARITY_EN
        wait_ready(ok);
        in_valid = 1'b1;
        in_code  = 3'd1;
        in_par   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("par_err_set", 32'(err), 32'h1);
        chk("par_no_pulse", 32'(out_onehot), 32'h0);
        chk("par_ready_low", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("par_ready_back", 32'(in_ready), 32'h1);
        pulse(3'd1, 4'd3, 8'h02, 3, 1'b0);
        chk("par_err_sticky", 32'(err), 32'h1);
`endif

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 2) != 0);
            set_code(3'($urandom));
            in_hold  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
`ifdef DECODER_3X8_PARITY_EN
            if ($urandom_range(0, 7) == 0) in_par = ~in_par;
`endif
            if (i == 300) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
